// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
//   Round sequencer for the switch/button guessing game. A free-running 8-bit
//   LFSR supplies the target when a round starts. Guesses are sampled on a
//   submit pulse, compared one cycle later, and the round either ends in
//   WIN/LOSE or shows a higher/lower hint for HINT_CYCLES clocks before
//   accepting the next guess.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        1-cycle pulse, start a round (IDLE/WIN/LOSE only)
//   submit_i       1-cycle pulse, sample guess_i (GUESS only)
//   guess_i        guess from the switches
//   target_o       target of the current round
//   state_o        encoded FSM state (IDLE=0 GUESS=1 CHECK=2 HINT=3 WIN=4 LOSE=5)
//   tries_left_o   wrong guesses still allowed
//   hint_hi_o      last guess was below target
//   hint_lo_o      last guess was above target
//   win_o, lose_o  round result
//
// Handshake: start_i and submit_i are single-cycle strobes with no ready
//   signal; a strobe arriving in a state that does not accept it is dropped.
//
// Optional feature: define GUESS_TIMEOUT_EN to treat TIMEOUT_CYCLES clocks in
//   GUESS without a submit as a wrong guess.
// -----------------------------------------------------------------------------
module guess_round_ctrl #(
  parameter int WIDTH          = 4,
  parameter int MAX_TRIES      = 4,
  parameter int HINT_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             submit_i,
  input  logic [WIDTH-1:0] guess_i,
  output logic [WIDTH-1:0] target_o,
  output logic [2:0]       state_o,
  output logic [3:0]       tries_left_o,
  output logic             hint_hi_o,
  output logic             hint_lo_o,
  output logic             win_o,
  output logic             lose_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GUESS = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_HINT  = 3'd3;
  localparam logic [2:0] S_WIN   = 3'd4;
  localparam logic [2:0] S_LOSE  = 3'd5;

  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [7:0] LFSR_SEED  = 8'hA5;

  // Hint counter only needs to reach HINT_CYCLES-1.
  localparam int             HW        = $clog2(HINT_CYCLES);
  localparam logic [HW-1:0]  HINT_LAST = HW'(HINT_CYCLES - 1);

  logic [2:0]       state_q,  state_d;
  logic [7:0]       lfsr_q,   lfsr_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [3:0]       tries_q,  tries_d;
  logic             hi_q,     hi_d;
  logic             lo_q,     lo_d;
  logic [HW-1:0]    hcnt_q,   hcnt_d;

`ifdef GUESS_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    guess_d  = guess_q;
    tries_d  = tries_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // Counters run only in their own state and sit at zero elsewhere, so
    // every entry into HINT/GUESS starts counting from zero.
    hcnt_d   = (state_q == S_HINT) ? hcnt_q + 1'b1 : '0;
`ifdef GUESS_TIMEOUT_EN
    tcnt_d   = (state_q == S_GUESS) ? tcnt_q + 1'b1 : '0;
`endif

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length). The zero check is a
    // lock-up guard only; a nonzero seed never reaches zero.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    if (lfsr_d == 8'h00) lfsr_d = LFSR_SEED;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_i) begin
          state_d  = S_GUESS;
          target_d = lfsr_q[WIDTH-1:0];
          tries_d  = TRIES_INIT;
          hi_d     = 1'b0;
          lo_d     = 1'b0;
        end
      end
      S_GUESS: begin
        if (submit_i) begin
          state_d = S_CHECK;
          guess_d = guess_i;
          hi_d    = 1'b0;
          lo_d    = 1'b0;
        end
`ifdef GUESS_TIMEOUT_EN
        else if (tcnt_q == TIME_LAST) begin
          hi_d = 1'b0;
          lo_d = 1'b0;
          if (tries_q == 4'd1) begin
            tries_d = 4'd0;
            state_d = S_LOSE;
          end else begin
            tries_d = tries_q - 4'd1;
            state_d = S_HINT;
          end
        end
`endif
      end
      S_CHECK: begin
        if (guess_q == target_q) begin
          state_d = S_WIN;
        end else if (tries_q == 4'd1) begin
          tries_d = 4'd0;
          state_d = S_LOSE;
        end else begin
          tries_d = tries_q - 4'd1;
          hi_d    = (guess_q < target_q);
          lo_d    = (guess_q > target_q);
          state_d = S_HINT;
        end
      end
      S_HINT: begin
        if (hcnt_q == HINT_LAST) state_d = S_GUESS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      target_q <= '0;
      guess_q  <= '0;
      tries_q  <= TRIES_INIT;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      hcnt_q   <= '0;
`ifdef GUESS_TIMEOUT_EN
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      guess_q  <= guess_d;
      tries_q  <= tries_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hcnt_q   <= hcnt_d;
`ifdef GUESS_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
`endif
    end
  end

  assign target_o     = target_q;
  assign state_o      = state_q;
  assign tries_left_o = tries_q;
  assign hint_hi_o    = hi_q;
  assign hint_lo_o    = lo_q;
  assign win_o        = (state_q == S_WIN);
  assign lose_o       = (state_q == S_LOSE);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_round_ctrl
//   Bench for guess_round_ctrl with HINT_CYCLES=4, TIMEOUT_CYCLES=20.
//   Inputs are driven and outputs sampled on the falling clock edge. A bench
//   LFSR predicts each round's target; expected CHECK results are queued when
//   a guess is submitted and compared when the result appears.
// -----------------------------------------------------------------------------
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       submit_i;
  logic [3:0] guess_i;
  logic [3:0] target_o;
  logic [2:0] state_o;
  logic [3:0] tries_left_o;
  logic       hint_hi_o;
  logic       hint_lo_o;
  logic       win_o;
  logic       lose_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];   // {state, tries, hint_hi, hint_lo}
  logic [7:0] m_lfsr;
  logic [3:0] m_target;
  logic [3:0] m_tries;

  guess_round_ctrl #(
    .WIDTH(4), .MAX_TRIES(4), .HINT_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .submit_i(submit_i),
    .guess_i(guess_i), .target_o(target_o), .state_o(state_o),
    .tries_left_o(tries_left_o), .hint_hi_o(hint_hi_o), .hint_lo_o(hint_lo_o),
    .win_o(win_o), .lose_o(lose_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference LFSR: x^8+x^6+x^5+x^4, shifting toward the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr = 8'hA5;
    else        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input string tag);
    m_target = m_lfsr[3:0];
    m_tries  = 4'd4;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    check_eq({tag, "_state"},  state_o, 3'd1);
    check_eq({tag, "_target"}, target_o, m_target);
    check_eq({tag, "_tries"},  tries_left_o, 4'd4);
    check_eq({tag, "_hints"},  {hint_hi_o, hint_lo_o}, 2'b00);
  endtask

  task automatic do_submit(input string tag, input logic [3:0] g);
    logic [8:0] e;
    if (g == m_target) begin
      e = {3'd4, m_tries, 2'b00};
    end else if (m_tries == 4'd1) begin
      m_tries = 4'd0;
      e = {3'd5, 4'd0, 2'b00};
    end else begin
      m_tries = m_tries - 4'd1;
      e = {3'd3, m_tries, (g < m_target), (g > m_target)};
    end
    exp_q.push_back(e);
    submit_i = 1'b1;
    guess_i  = g;
    step();
    submit_i = 1'b0;
    check_eq({tag, "_chk_state"}, state_o, 3'd2);
    step();
    check_eq({tag, "_sb_avail"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_state"}, state_o, e[8:6]);
      check_eq({tag, "_tries"}, tries_left_o, e[5:2]);
      check_eq({tag, "_hints"}, {hint_hi_o, hint_lo_o}, e[1:0]);
      check_eq({tag, "_win"},   win_o,  e[8:6] == 3'd4);
      check_eq({tag, "_lose"},  lose_o, e[8:6] == 3'd5);
    end
  endtask

  // HINT lasts 4 clocks from its entry edge, then GUESS with hints kept.
  task automatic wait_hint(input string tag);
    logic [1:0] h;
    h = {hint_hi_o, hint_lo_o};
    repeat (3) step();
    check_eq({tag, "_still_hint"}, state_o, 3'd3);
    step();
    check_eq({tag, "_back_guess"}, state_o, 3'd1);
    check_eq({tag, "_hint_kept"}, {hint_hi_o, hint_lo_o}, h);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    submit_i = 1'b0;
    guess_i  = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. idle after reset
    repeat (10) step();
    check_eq("rst_state", state_o, 3'd0);
    check_eq("rst_tries", tries_left_o, 4'd4);
    check_eq("rst_target", target_o, 4'd0);
    check_eq("rst_flags", {win_o, lose_o, hint_hi_o, hint_lo_o}, 4'b0000);

    // 2. correct first guess
    do_start("win_start");
    do_submit("win_sub", m_target);
    repeat (3) step();
    check_eq("win_hold", state_o, 3'd4);
    check_eq("win_target_hold", target_o, m_target);

    // 3. target 9: low guess then high guess
    for (int i = 0; i < 300 && m_lfsr[3:0] != 4'd9; i++) step();
    check_eq("find_target9", m_lfsr[3:0], 4'd9);
    do_start("t9_start");
    do_submit("t9_low", 4'd3);
    wait_hint("t9_low");
    do_submit("t9_high", 4'd12);
    wait_hint("t9_high");
    do_submit("t9_hit", 4'd9);

    // 4. four wrong guesses -> LOSE, restart from LOSE
    do_start("lose_start");
    for (int i = 0; i < 4; i++) begin
      do_submit("lose_sub", m_target ^ 4'($urandom_range(1, 15)));
      if (i < 3) wait_hint("lose");
    end
    repeat (2) step();
    check_eq("lose_hold", lose_o, 1'b1);
    check_eq("lose_tries_hold", tries_left_o, 4'd0);
    do_start("lose_restart");

    // 5. ignored strobes and mid-round reset
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_eq("ign_start_guess_state", state_o, 3'd1);
    check_eq("ign_start_guess_target", target_o, m_target);
    do_submit("ign_sub", m_target ^ 4'h8);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check_eq("ign_start_hint_state", state_o, 3'd3);
    check_eq("ign_start_hint_target", target_o, m_target);
    submit_i = 1'b1;
    guess_i  = m_target;
    step();
    submit_i = 1'b0;
    check_eq("ign_sub_hint_state", state_o, 3'd3);
    check_eq("ign_sub_hint_tries", tries_left_o, m_tries);
    rst_n = 1'b0;
    #1;
    check_eq("abort_state", state_o, 3'd0);
    check_eq("abort_tries", tries_left_o, 4'd4);
    check_eq("abort_target", target_o, 4'd0);
    check_eq("abort_hints", {hint_hi_o, hint_lo_o}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifdef GUESS_TIMEOUT_EN
    // 6. timeout as a wrong guess; submit wins over a simultaneous timeout
    do_start("to_start");
    repeat (19) step();
    check_eq("to_before", state_o, 3'd1);
    step();
    m_tries = m_tries - 4'd1;
    check_eq("to_state", state_o, 3'd3);
    check_eq("to_tries", tries_left_o, m_tries);
    check_eq("to_hints", {hint_hi_o, hint_lo_o}, 2'b00);
    wait_hint("to");
    repeat (19) step();
    do_submit("to_race", m_target ^ 4'h2);
`endif

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
